// File: rtl/hms_counter.sv
// Time-of-day counter holding hours, minutes and seconds as packed BCD.
// Advances one second per qualified tick and supports a validated time load.
module hms_counter #(
    parameter int HOUR_MODULO = 24
) (
    input  logic       hms_clock,
    input  logic       hms_reset,
    input  logic       hms_tick,
    input  logic       hms_run,
    input  logic       hms_load,
    input  logic [7:0] hms_load_hour,
    input  logic [7:0] hms_load_min,
    input  logic [7:0] hms_load_sec,
    output logic [7:0] hms_hour,
    output logic [7:0] hms_min,
    output logic [7:0] hms_sec,
    output logic       hms_day_carry,
    output logic       hms_load_err
);

    localparam logic [6:0] HOUR_LIMIT     = 7'(HOUR_MODULO);
    localparam logic [3:0] HOUR_MAX_TENS  = 4'((HOUR_MODULO - 1) / 10);
    localparam logic [3:0] HOUR_MAX_UNITS = 4'((HOUR_MODULO - 1) % 10);
    localparam logic [7:0] HOUR_MAX       = {HOUR_MAX_TENS, HOUR_MAX_UNITS};

    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       dayCarry_q, dayCarry_d;
    logic       loadErr_q, loadErr_d;

    logic       secWrap, minWrap, hourWrap;
    logic [7:0] secInc, minInc, hourInc;
    logic       loadValid;
    logic       tickEn;

    // Adds one to a packed BCD byte; callers handle the wrap value themselves.
    function automatic logic [7:0] bcdIncrement(input logic [7:0] value);
        if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

    // Both nibbles must be decimal digits.
    function automatic logic bcdDigitsOk(input logic [7:0] value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

    // Converts a packed BCD byte (already known to hold decimal digits) to binary.
    function automatic logic [6:0] bcdToBin(input logic [7:0] value);
        return (7'(value[7:4]) * 7'd10) + 7'(value[3:0]);
    endfunction

    // Per-field increment values, wrap detection and load validation.
    always_comb begin
        secWrap   = (sec_q == 8'h59);
        minWrap   = (min_q == 8'h59);
        hourWrap  = (hour_q == HOUR_MAX);
        secInc    = secWrap  ? 8'h00 : bcdIncrement(sec_q);
        minInc    = minWrap  ? 8'h00 : bcdIncrement(min_q);
        hourInc   = hourWrap ? 8'h00 : bcdIncrement(hour_q);
        loadValid = bcdDigitsOk(hms_load_hour) && bcdDigitsOk(hms_load_min) &&
                    bcdDigitsOk(hms_load_sec) &&
                    (hms_load_sec < 8'h60) && (hms_load_min < 8'h60) &&
                    (bcdToBin(hms_load_hour) < HOUR_LIMIT);
        tickEn    = hms_tick && hms_run && !hms_load;
    end

    // Next-state selection: load wins over a simultaneous tick, which is dropped.
    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        dayCarry_d = 1'b0;
        loadErr_d  = 1'b0;
        if (hms_load) begin
            if (loadValid) begin
                hour_d = hms_load_hour;
                min_d  = hms_load_min;
                sec_d  = hms_load_sec;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (tickEn) begin
            sec_d = secInc;
            if (secWrap) begin
                min_d = minInc;
                if (minWrap) begin
                    hour_d     = hourInc;
                    dayCarry_d = hourWrap;
                end
            end
        end
    end

    // Time registers and registered one-cycle pulses, cleared asynchronously.
    always_ff @(posedge hms_clock or negedge hms_reset) begin
        if (!hms_reset) begin
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            dayCarry_q <= 1'b0;
            loadErr_q  <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            dayCarry_q <= dayCarry_d;
            loadErr_q  <= loadErr_d;
        end
    end

    assign hms_hour      = hour_q;
    assign hms_min       = min_q;
    assign hms_sec       = sec_q;
    assign hms_day_carry = dayCarry_q;
    assign hms_load_err  = loadErr_q;

endmodule

// File: tb/tb_hms_counter.sv
// Self-checking bench for hms_counter: a table of single-cycle vectors plus
// hand-written multi-cycle sequences (tick spacing, freeze, async reset, 12-hour build).
module tb_hms_counter;

    typedef struct packed {
        logic       tick;
        logic       run;
        logic       load;
        logic [7:0] lh;
        logic [7:0] lm;
        logic [7:0] ls;
        logic [7:0] eh;
        logic [7:0] em;
        logic [7:0] es;
        logic       ec;
        logic       ee;
    } vector_t;

    logic       hmsClock;
    logic       hmsReset;
    logic       hmsTick;
    logic       hmsRun;
    logic       hmsLoad;
    logic [7:0] loadHour, loadMin, loadSec;
    logic [7:0] hour24, min24, sec24;
    logic       carry24, err24;
    logic [7:0] hour12, min12, sec12;
    logic       carry12, err12;

    int testsRun;
    int testsFailed;

    vector_t vecs[23];

    hms_counter #(.HOUR_MODULO(24)) dut (
        .hms_clock    (hmsClock),
        .hms_reset    (hmsReset),
        .hms_tick     (hmsTick),
        .hms_run      (hmsRun),
        .hms_load     (hmsLoad),
        .hms_load_hour(loadHour),
        .hms_load_min (loadMin),
        .hms_load_sec (loadSec),
        .hms_hour     (hour24),
        .hms_min      (min24),
        .hms_sec      (sec24),
        .hms_day_carry(carry24),
        .hms_load_err (err24)
    );

    hms_counter #(.HOUR_MODULO(12)) dut12 (
        .hms_clock    (hmsClock),
        .hms_reset    (hmsReset),
        .hms_tick     (hmsTick),
        .hms_run      (hmsRun),
        .hms_load     (hmsLoad),
        .hms_load_hour(loadHour),
        .hms_load_min (loadMin),
        .hms_load_sec (loadSec),
        .hms_hour     (hour12),
        .hms_min      (min12),
        .hms_sec      (sec12),
        .hms_day_carry(carry12),
        .hms_load_err (err12)
    );

    // Free-running 10 ns system clock.
    initial begin
        hmsClock = 1'b0;
        forever #5 hmsClock = ~hmsClock;
    end

    // Compares {hour,min,sec,carry,err} tuples and reports any difference.
    task automatic checkOutput(input string name, input logic [25:0] actual,
                               input logic [25:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h:%h:%h carry=%b err=%b, want %h:%h:%h carry=%b err=%b",
                     name, actual[25:18], actual[17:10], actual[9:2], actual[1], actual[0],
                     expected[25:18], expected[17:10], expected[9:2], expected[1], expected[0]);
        end
    endtask

    // Drives one vector for exactly one rising edge, then returns inputs to idle.
    task automatic applyStimulus(input vector_t v);
        @(negedge hmsClock);
        hmsTick  = v.tick;
        hmsRun   = v.run;
        hmsLoad  = v.load;
        loadHour = v.lh;
        loadMin  = v.lm;
        loadSec  = v.ls;
        @(posedge hmsClock);
        #1;
        hmsTick = 1'b0;
        hmsLoad = 1'b0;
    endtask

    // Issues n ticks spaced gap cycles apart with the given run level.
    task automatic tickRun(input int n, input int gap, input logic runVal);
        hmsRun = runVal;
        for (int i = 0; i < n; i++) begin
            @(negedge hmsClock);
            hmsTick = 1'b1;
            for (int g = 1; g < gap; g++) begin
                @(negedge hmsClock);
                hmsTick = 1'b0;
            end
        end
        @(negedge hmsClock);
        hmsTick = 1'b0;
    endtask

    // Asserts reset away from a clock edge and releases it on a falling edge.
    task automatic doReset();
        #2;
        hmsReset = 1'b0;
        repeat (3) @(negedge hmsClock);
        hmsReset = 1'b1;
    endtask

    // Main test sequence.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        hmsReset    = 1'b0;
        hmsTick     = 1'b0;
        hmsRun      = 1'b0;
        hmsLoad     = 1'b0;
        loadHour    = 8'h00;
        loadMin     = 8'h00;
        loadSec     = 8'h00;

        //            tick  run   load  lh     lm     ls     eh     em     es     ec    ee
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h09, 8'h59, 8'h59, 8'h09, 8'h59, 8'h59, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h05, 8'h09, 8'h59, 8'h05, 8'h09, 8'h59, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h10, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h19, 8'h59, 8'h59, 8'h19, 8'h59, 8'h59, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h60, 8'h12, 8'h34, 8'h57, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h3A, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h24, 8'h00, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h1A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h0F, 8'h12, 8'h34, 8'h57, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h57, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 8'h24, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};

        repeat (3) @(negedge hmsClock);
        checkOutput("reset_state", {hour24, min24, sec24, carry24, err24}, 26'd0);
        hmsReset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vector_%0d", i), {hour24, min24, sec24, carry24, err24},
                        {vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ec, vecs[i].ee});
        end

        // 61 back-to-back ticks from midnight
        doReset();
        tickRun(61, 1, 1'b1);
        checkOutput("count61_gap1", {hour24, min24, sec24, carry24, err24},
                    {8'h00, 8'h01, 8'h01, 1'b0, 1'b0});

        // 61 ticks spaced 500 cycles apart must land on the same time
        doReset();
        tickRun(61, 500, 1'b1);
        checkOutput("count61_gap500", {hour24, min24, sec24, carry24, err24},
                    {8'h00, 8'h01, 8'h01, 1'b0, 1'b0});

        // Frozen ticks are ignored, then a running tick advances one second
        tickRun(10, 2, 1'b0);
        checkOutput("freeze_10", {hour24, min24, sec24, carry24, err24},
                    {8'h00, 8'h01, 8'h01, 1'b0, 1'b0});
        tickRun(1, 1, 1'b1);
        checkOutput("unfreeze_1", {hour24, min24, sec24, carry24, err24},
                    {8'h00, 8'h01, 8'h02, 1'b0, 1'b0});

        // Reset mid-pulse clears outputs and carry without waiting for a clock edge
        applyStimulus('{1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h59, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        applyStimulus('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        checkOutput("carry_before_reset", {hour24, min24, sec24, carry24, err24},
                    {8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
        #1;
        hmsReset = 1'b0;
        #1;
        checkOutput("async_reset_clear", {hour24, min24, sec24, carry24, err24}, 26'd0);
        @(negedge hmsClock);
        hmsReset = 1'b1;

        // 12-hour build: 11:59:59 rolls to 00:00:00, hour 12 is rejected
        applyStimulus('{1'b0, 1'b1, 1'b1, 8'h11, 8'h59, 8'h59, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        checkOutput("mod12_load", {hour12, min12, sec12, carry12, err12},
                    {8'h11, 8'h59, 8'h59, 1'b0, 1'b0});
        applyStimulus('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        checkOutput("mod12_rollover", {hour12, min12, sec12, carry12, err12},
                    {8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
        applyStimulus('{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        checkOutput("mod12_carry_drop", {hour12, min12, sec12, carry12, err12},
                    {8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        applyStimulus('{1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
        checkOutput("mod12_bad_hour", {hour12, min12, sec12, carry12, err12},
                    {8'h00, 8'h00, 8'h00, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
